// File: rtl/spi_slave_mmio_if.sv
// spi_slave_mmio_if: dmem-style register bus between the CPU and the SPI slave.
// The master side drives the strobes, the slave side returns rdata.
interface spi_slave_mmio_if;
  logic        sel;
  logic        we;
  logic        re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel, we, re, addr, wdata,
    input  rdata
  );

  modport slave (
    input  sel, we, re, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/spi_slave_mmio.sv
// spi_slave_mmio: oversampled any-mode SPI slave with RX FIFO and TX/RX/STATUS regs.
// Define SPI_IRQ_EN to build the registered RX-not-empty interrupt; otherwise irq=0.
module spi_slave_mmio #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_slave_mmio_if.slave bus,
  input  logic            spi_sclk,
  input  logic            spi_cs_n,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  output logic            irq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [5:0] LAST = 6'(WORD_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [2:0]        r_sclk_s;
  logic [2:0]        r_cs_s;
  logic [1:0]        r_mosi_s;
  logic [1:0]        r_state;
  logic [5:0]        r_bit_cnt;
  logic [WORD_W-1:0] r_shift_in;
  logic [WORD_W-1:0] r_shift_out;
  logic [WORD_W-1:0] r_tx_reg;
  logic              r_tx_pending;
  logic              r_rx_ovf;
  logic              r_tx_unf;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_cnt;

  logic              w_edge, w_lead, w_trail;
  logic              w_sample, w_shift;
  logic              w_cs_fall, w_cs_rise;
  logic              w_push, w_push_ok, w_pop, w_load, w_wr;
  logic [WORD_W-1:0] w_rx_word;
  logic [AW:0]       w_cnt_nxt;
  logic              w_unused;

  assign w_edge    = r_sclk_s[1] ^ r_sclk_s[2];
  assign w_lead    = w_edge & (r_sclk_s[1] != CPOL);
  assign w_trail   = w_edge & (r_sclk_s[1] == CPOL);
  assign w_sample  = CPHA ? w_trail : w_lead;
  assign w_shift   = CPHA ? w_lead : w_trail;
  assign w_cs_fall = r_cs_s[2] & ~r_cs_s[1];
  assign w_cs_rise = ~r_cs_s[2] & r_cs_s[1];
  assign w_rx_word = {r_shift_in[WORD_W-2:0], r_mosi_s[1]};

  assign w_push    = (r_state == S_SHIFT) & w_sample & (r_bit_cnt == LAST);
  assign w_pop     = bus.sel & bus.re & (bus.addr == 2'd1) & (r_cnt != '0);
  assign w_push_ok = w_push & ((r_cnt != FULL) | w_pop);
  assign w_load    = (r_state == S_LOAD) & ~w_cs_rise;
  assign w_wr      = bus.sel & bus.we;
  assign w_unused  = ^bus.wdata;

  assign spi_miso_oe = (r_state != S_IDLE);
  assign spi_miso    = spi_miso_oe & r_shift_out[WORD_W-1];

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push_ok && !w_pop)
      w_cnt_nxt = r_cnt + (AW+1)'(1);
    else if (!w_push_ok && w_pop)
      w_cnt_nxt = r_cnt - (AW+1)'(1);
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0: bus.rdata = 32'(r_tx_reg);
      2'd1: if (r_cnt != '0) bus.rdata = 32'(r_mem[r_rp]);
      2'd2: bus.rdata = {21'd0, r_tx_unf, r_rx_ovf,
                         r_tx_pending, 8'(r_cnt)};
      default: bus.rdata = '0;
    endcase
  end

  // cs sync resets to "asserted" so a CE held low across reset never frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s <= {3{CPOL}};
      r_cs_s   <= '0;
      r_mosi_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], spi_sclk};
      r_cs_s   <= {r_cs_s[1:0], spi_cs_n};
      r_mosi_s <= {r_mosi_s[0], spi_mosi};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
    end else if (w_cs_rise) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_bit_cnt <= '0;
          if (w_cs_fall) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift_out <= r_tx_pending ? r_tx_reg : '0;
          r_state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_sample) begin
            r_shift_in <= w_rx_word;
            if (r_bit_cnt == LAST) begin
              r_bit_cnt <= '0;
              r_state   <= S_LOAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
          // bit_cnt==0 marks the edge that presents the MSB, not a shift
          if (w_shift && r_bit_cnt != '0)
            r_shift_out <= {r_shift_out[WORD_W-2:0], 1'b0};
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_reg     <= '0;
      r_tx_pending <= 1'b0;
      r_rx_ovf     <= 1'b0;
      r_tx_unf     <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_pending <= 1'b0;
        if (!r_tx_pending) r_tx_unf <= 1'b1;
      end
      if (w_push && !w_push_ok) r_rx_ovf <= 1'b1;
      if (w_wr) begin
        case (bus.addr)
          2'd0: begin
            r_tx_reg     <= bus.wdata[WORD_W-1:0];
            r_tx_pending <= 1'b1;
          end
          2'd2: begin
            if (bus.wdata[9])  r_rx_ovf <= 1'b0;
            if (bus.wdata[10]) r_tx_unf <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= w_rx_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + AW'(1);
      if (w_pop)     r_rp <= r_rp + AW'(1);
      r_cnt <= w_cnt_nxt;
    end
  end

`ifdef SPI_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= (w_cnt_nxt != '0);
  end
  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_mmio.sv
// tb_spi_slave_mmio: mode-0/32-bit and mode-3/8-bit slaves share one SPI master
// and one register bus; a queue-based model predicts FIFO, flags and MISO.
module tb_spi_slave_mmio;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel, we, re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        sclk, sclk1, cs_n, mosi;
  logic        miso0, oe0, irq0, miso1, oe1, irq1;

  spi_slave_mmio_if b0 ();
  spi_slave_mmio_if b1 ();
  assign b0.sel = sel;   assign b1.sel = sel;
  assign b0.we = we;     assign b1.we = we;
  assign b0.re = re;     assign b1.re = re;
  assign b0.addr = addr; assign b1.addr = addr;
  assign b0.wdata = wdata; assign b1.wdata = wdata;
  assign sclk1 = ~sclk;

  spi_slave_mmio #(.WORD_W(32), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0),
    .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(oe0), .irq(irq0));

  spi_slave_mmio #(.WORD_W(8), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1),
    .spi_sclk(sclk1), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso1), .spi_miso_oe(oe1), .irq(irq1));

  int n_cmp = 0;
  int n_bad = 0;
  bit quiet = 1'b0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] m_tx;
  bit          m_pend [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  logic [31:0] t0, t1;
  logic [63:0] g0, g1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] msk(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void m_push(input int d, input logic [31:0] v);
    if (qsize(d) == 4) m_ovf[d] = 1'b1;
    else if (d == 0) q0.push_back(v);
    else q1.push_back(v);
  endfunction

  function automatic logic [31:0] m_pop(input int d);
    if (qsize(d) == 0) return 32'd0;
    return (d == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic logic [31:0] m_load(input int d);
    logic [31:0] r;
    if (m_pend[d]) r = m_tx & msk(d);
    else begin
      r = 32'd0;
      m_unf[d] = 1'b1;
    end
    m_pend[d] = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] m_status(input int d);
    return {21'd0, m_unf[d], m_ovf[d], m_pend[d], 8'(qsize(d))};
  endfunction

  function automatic logic m_irq(input int d);
`ifdef SPI_IRQ_EN
    return qsize(d) != 0;
`else
    return 1'b0 & (d == 0);
`endif
  endfunction

  function automatic void m_reset();
    q0.delete();
    q1.delete();
    m_tx = 32'd0;
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 1'b0;
      m_ovf[d] = 1'b0;
      m_unf[d] = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    if (quiet && reset_n && addr == 2'd2 && !we && !re) begin
      chk("status0", b0.rdata, m_status(0));
      chk("status1", b1.rdata, m_status(1));
      chk("irq0", irq0, m_irq(0));
      chk("irq1", irq1, m_irq(1));
      chk("oe0_idle", oe0, 1'b0);
      chk("oe1_idle", oe1, 1'b0);
    end
  end

  task automatic ph();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; addr = 2'd2;
    if (a == 2'd0) begin
      m_tx = d;
      m_pend[0] = 1'b1;
      m_pend[1] = 1'b1;
    end else if (a == 2'd2) begin
      for (int k = 0; k < 2; k++) begin
        if (d[9])  m_ovf[k] = 1'b0;
        if (d[10]) m_unf[k] = 1'b0;
      end
    end
  endtask

  task automatic rd_rx(output logic [31:0] r0, output logic [31:0] r1);
    sel = 1'b1; re = 1'b1; addr = 2'd1;
    @(negedge clk);
    r0 = b0.rdata;
    r1 = b1.rdata;
    @(posedge clk); #1;
    sel = 1'b0; re = 1'b0; addr = 2'd2;
    chk("rx0", r0, m_pop(0));
    chk("rx1", r1, m_pop(1));
  endtask

  task automatic frame(input logic [63:0] data, input int n, input bit co,
                       output logic [63:0] o0, output logic [63:0] o1);
    logic [63:0] e0, e1, c0, c1;
    logic [31:0] l0, l1, p, pc0, pc1;
    int wd, nf;
    quiet = 1'b0;
    o0 = '0; o1 = '0; e0 = '0; e1 = '0; c0 = '0; c1 = '0;
    pc0 = '0; pc1 = '0;
    l0 = m_load(0);
    l1 = m_load(1);
    for (int i = 0; i < n; i++) begin
      if (i < 32) e0 = {e0[62:0], l0[31-i]};
      else e0 = {e0[62:0], 1'b0};
      if (i < 8) e1 = {e1[62:0], l1[7-i]};
      else e1 = {e1[62:0], 1'b0};
    end
    cs_n = 1'b0;
    ph(); ph();
    for (int i = 0; i < n; i++) begin
      mosi = data[n-1-i];
      ph();
      o0 = {o0[62:0], miso0};
      sclk = 1'b1;
      if (co && i == n - 1) begin
        repeat (2) @(posedge clk);
        #1;
        sel = 1'b1; re = 1'b1; addr = 2'd1;
        @(negedge clk);
        c0 = 64'(b0.rdata);
        c1 = 64'(b1.rdata);
        @(posedge clk); #1;
        sel = 1'b0; re = 1'b0; addr = 2'd2;
        @(posedge clk); #1;
      end else begin
        ph();
      end
      o1 = {o1[62:0], miso1};
      sclk = 1'b0;
      ph();
    end
    chk("oe0_active", oe0, 1'b1);
    chk("oe1_active", oe1, 1'b1);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("oe0_csrise", oe0, 1'b0);
    chk("oe1_csrise", oe1, 1'b0);
    @(posedge clk); #1;
    ph();
    chk("miso0", o0, e0);
    chk("miso1", o1, e1);
    for (int d = 0; d < 2; d++) begin
      wd = (d == 0) ? 32 : 8;
      nf = n / wd;
      for (int j = 0; j < nf; j++) begin
        p = 32'(data >> (n - (j + 1) * wd)) & msk(d);
        if (co && j == nf - 1) begin
          if (d == 0) pc0 = m_pop(0);
          else pc1 = m_pop(1);
        end
        m_push(d, p);
      end
      for (int j = 0; j < nf; j++) void'(m_load(d));
    end
    if (co) begin
      chk("co_rx0", c0, 64'(pc0));
      chk("co_rx1", c1, 64'(pc1));
    end
    quiet = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; we = 1'b0; re = 1'b0; addr = 2'd2; wdata = '0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata0", b0.rdata, 32'd0);
    chk("rst_rdata1", b1.rdata, 32'd0);
    chk("rst_miso0", miso0, 1'b0);
    chk("rst_oe0", oe0, 1'b0);
    chk("rst_irq0", irq0, 1'b0);
    chk("rst_oe1", oe1, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ph();
    quiet = 1'b1;

    wr(2'd0, 32'hCAFE_F00D);
    frame(64'h1234_5678, 32, 1'b0, g0, g1);
    chk("lit_miso0", g0[31:0], 32'hCAFE_F00D);
    chk("lit_cnt0", b0.rdata[7:0], 8'd1);
    chk("lit_cnt1", b1.rdata[7:0], 8'd4);
    rd_rx(t0, t1);
    chk("lit_rx0", t0, 32'h1234_5678);
    chk("lit_rx1", t1, 32'h12);
    @(negedge clk);
    chk("lit_cnt0_after", b0.rdata[7:0], 8'd0);
    @(posedge clk); #1;
    repeat (3) rd_rx(t0, t1);
    chk("lit_rx0_empty", t0, 32'd0);
    chk("lit_rx1_last", t1, 32'h78);

    wr(2'd2, 32'h600);
    frame(64'hA53C, 16, 1'b0, g0, g1);
    chk("lit_m3_cnt", b1.rdata[7:0], 8'd2);
    chk("lit_m3_unf", b1.rdata[10], 1'b1);
    chk("lit_m3_miso", g1[15:0], 16'h0000);
    chk("lit_m0_partial", b0.rdata[7:0], 8'd0);
    rd_rx(t0, t1);
    chk("lit_m3_b0", t1, 32'hA5);
    rd_rx(t0, t1);
    chk("lit_m3_b1", t1, 32'h3C);

    wr(2'd0, 32'h0000_5A5A);
    frame(64'h1_2345, 13, 1'b0, g0, g1);
    chk("lit_part_cnt0", b0.rdata[7:0], 8'd0);
    chk("lit_part_miso1", g1[12:5], 8'h5A);
    rd_rx(t0, t1);

    wr(2'd2, 32'h600);
    for (int k = 0; k < 5; k++)
      frame(64'($urandom), 32, 1'b0, g0, g1);
    chk("lit_ovf_cnt", b0.rdata[7:0], 8'd4);
    chk("lit_ovf_flag", b0.rdata[9], 1'b1);
    wr(2'd2, 32'h200);
    chk("lit_ovf_clr", b0.rdata[9], 1'b0);

    frame(64'($urandom), 32, 1'b1, g0, g1);
    chk("lit_co_cnt", b0.rdata[7:0], 8'd4);
    chk("lit_co_ovf", b0.rdata[9], 1'b0);
    repeat (5) rd_rx(t0, t1);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) wr(2'd0, $urandom);
      frame({$urandom, $urandom}, int'($urandom_range(1, 64)), 1'b0, g0, g1);
      repeat ($urandom_range(0, 3)) rd_rx(t0, t1);
      if ($urandom_range(0, 3) == 0) wr(2'd2, 32'h600);
    end

    wr(2'd0, 32'h0BAD_BEEF);
    quiet = 1'b0;
    cs_n = 1'b0;
    ph(); ph();
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom);
      ph(); sclk = 1'b1; ph(); sclk = 1'b0; ph();
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_rdata0", b0.rdata, 32'd0);
    chk("mrst_rdata1", b1.rdata, 32'd0);
    chk("mrst_oe0", oe0, 1'b0);
    chk("mrst_oe1", oe1, 1'b0);
    chk("mrst_miso0", miso0, 1'b0);
    chk("mrst_irq0", irq0, 1'b0);
    m_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      ph(); sclk = 1'b1; ph(); sclk = 1'b0; ph();
    end
    cs_n = 1'b1;
    ph(); ph();
    quiet = 1'b1;
    frame(64'hDEAD_4321, 32, 1'b0, g0, g1);
    chk("lit_mrst_cnt0", b0.rdata[7:0], 8'd1);
    rd_rx(t0, t1);
    chk("lit_mrst_rx0", t0, 32'hDEAD_4321);
    repeat (4) rd_rx(t0, t1);
    ph();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
